fifo_rr_ctrl: RTL and testbench

- Controller that shares the 16-bit FIFO write port between two producers and paces the FIFO read port into a one-entry output register for a single consumer.
- Sits between producer blocks, the kadai3-style FIFO (DIN/WR/FULL on write, RD/DOUT/VALID/EMPTY on read) and the downstream squarer.
- Write side: round-robin arbitration with a burst limit. Read side: RD throttling so no read data is ever dropped.

---
 rtl/fifo_rr_ctrl.sv | 142 ++++++++++++++
 tb/tb_fifo_rr_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_ctrl.sv
// fifo_rr_ctrl
//   Shares one FIFO write port between two producers using round-robin
//   arbitration with a burst limit. Paces the FIFO read port into a one-entry
//   output register for a single consumer, so that read data is never dropped.
//
// Parameters:
//   DW     data width of requester, FIFO and output data
//   BURST  max consecutive grants to one requester while the other waits (1..15)
//
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   REQn_VALID/REQn_DATA/REQn_READY  requester n, zero-latency handshake
//   FIFO_WR/FIFO_DIN/FIFO_FULL      FIFO write side
//   FIFO_RD/FIFO_DOUT/FIFO_VALID/FIFO_EMPTY  FIFO read side (data one cycle after RD)
//   OUT_VALID/OUT_DATA/OUT_READY    output register to consumer
//
// Optional feature (macro FIFO_RR_CTRL_STATS_EN):
//   GNT0_CNT/GNT1_CNT  saturating per-requester accepted-write counters
//   DROP_CNT           FIFO_VALID pulses seen with no read in flight
module fifo_rr_ctrl #(
   parameter int unsigned DW    = 16,
   parameter int unsigned BURST = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          REQ0_VALID,
   input  logic [DW-1:0] REQ0_DATA,
   output logic          REQ0_READY,
   input  logic          REQ1_VALID,
   input  logic [DW-1:0] REQ1_DATA,
   output logic          REQ1_READY,
   output logic          FIFO_WR,
   output logic [DW-1:0] FIFO_DIN,
   input  logic          FIFO_FULL,
   output logic          FIFO_RD,
   input  logic [DW-1:0] FIFO_DOUT,
   input  logic          FIFO_VALID,
   input  logic          FIFO_EMPTY,
   output logic          OUT_VALID,
   output logic [DW-1:0] OUT_DATA,
   input  logic          OUT_READY
`ifdef FIFO_RR_CTRL_STATS_EN
   ,
   output logic [15:0]   GNT0_CNT,
   output logic [15:0]   GNT1_CNT,
   output logic [15:0]   DROP_CNT
`endif
);

   localparam logic [3:0] BURST_MAX = 4'(BURST);

   logic          last_gnt;
   logic [3:0]    burst_cnt;
   logic          inflight;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          sel;
   logic          sel_valid;
   logic          accept;
   logic          rd;
   logic          load;

   // A burst is only "ongoing" once at least one grant has been counted; with
   // burst_cnt == 0 (after reset) plain alternation applies, so requester 0
   // wins first because last_gnt resets to 1.
   always_comb begin
      sel       = 1'b0;
      sel_valid = REQ0_VALID | REQ1_VALID;
      if (REQ0_VALID && !REQ1_VALID)
         sel = 1'b0;
      else if (REQ1_VALID && !REQ0_VALID)
         sel = 1'b1;
      else if ((burst_cnt != '0) && (burst_cnt < BURST_MAX))
         sel = last_gnt;
      else
         sel = ~last_gnt;
   end

   always_comb begin
      accept     = sel_valid & ~FIFO_FULL & ~RST;
      FIFO_WR    = accept;
      FIFO_DIN   = '0;
      if (accept)
         FIFO_DIN = sel ? REQ1_DATA : REQ0_DATA;
      REQ0_READY = accept & ~sel;
      REQ1_READY = accept & sel;
      // One read outstanding at a time, and only when the output register
      // is free or being emptied this cycle: returning data always has a slot.
      rd         = ~FIFO_EMPTY & ~inflight & (~out_valid | OUT_READY) & ~RST;
      FIFO_RD    = rd;
      // Data returning with nothing in flight (e.g. a read cut off by reset)
      // is ignored.
      load       = FIFO_VALID & inflight;
      OUT_VALID  = out_valid;
      OUT_DATA   = out_data;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         last_gnt  <= 1'b1;
         burst_cnt <= '0;
         inflight  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (accept) begin
            if (sel == last_gnt) begin
               if (burst_cnt < BURST_MAX)
                  burst_cnt <= burst_cnt + 4'd1;
            end else begin
               last_gnt  <= sel;
               burst_cnt <= 4'd1;
            end
         end
         inflight <= rd;
         if (load) begin
            out_data  <= FIFO_DOUT;
            out_valid <= 1'b1;
         end else if (out_valid && OUT_READY) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef FIFO_RR_CTRL_STATS_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         GNT0_CNT <= '0;
         GNT1_CNT <= '0;
         DROP_CNT <= '0;
      end else begin
         if (REQ0_READY && (GNT0_CNT != '1))
            GNT0_CNT <= GNT0_CNT + 16'd1;
         if (REQ1_READY && (GNT1_CNT != '1))
            GNT1_CNT <= GNT1_CNT + 16'd1;
         if (FIFO_VALID && !inflight && (DROP_CNT != '1))
            DROP_CNT <= DROP_CNT + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_rr_ctrl.sv
// tb_fifo_rr_ctrl
//   Directed bench for fifo_rr_ctrl with a behavioural FIFO model (read data
//   one cycle after FIFO_RD) and a word scoreboard for the random phase.
//   Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_fifo_rr_ctrl;

   localparam int DEPTH = 16;

   logic        CLK = 1'b0;
   logic        RST;
   logic        REQ0_VALID, REQ1_VALID, REQ0_READY, REQ1_READY;
   logic [15:0] REQ0_DATA, REQ1_DATA;
   logic        FIFO_WR, FIFO_FULL, FIFO_RD, FIFO_VALID, FIFO_EMPTY;
   logic [15:0] FIFO_DIN, FIFO_DOUT;
   logic        OUT_VALID, OUT_READY;
   logic [15:0] OUT_DATA;
`ifdef FIFO_RR_CTRL_STATS_EN
   logic [15:0] GNT0_CNT, GNT1_CNT, DROP_CNT;
`endif

   int          vectors = 0;
   int          miscompares = 0;

   // FIFO model controls
   logic [15:0] fq[$];
   int          q_size;
   logic        force_full, hold_empty, load_en;
   logic [15:0] load_data;

   always #5 CLK = ~CLK;

   fifo_rr_ctrl #(.DW(16), .BURST(4)) dut (
      .CLK(CLK), .RST(RST),
      .REQ0_VALID(REQ0_VALID), .REQ0_DATA(REQ0_DATA), .REQ0_READY(REQ0_READY),
      .REQ1_VALID(REQ1_VALID), .REQ1_DATA(REQ1_DATA), .REQ1_READY(REQ1_READY),
      .FIFO_WR(FIFO_WR), .FIFO_DIN(FIFO_DIN), .FIFO_FULL(FIFO_FULL),
      .FIFO_RD(FIFO_RD), .FIFO_DOUT(FIFO_DOUT), .FIFO_VALID(FIFO_VALID),
      .FIFO_EMPTY(FIFO_EMPTY),
      .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .OUT_READY(OUT_READY)
`ifdef FIFO_RR_CTRL_STATS_EN
      , .GNT0_CNT(GNT0_CNT), .GNT1_CNT(GNT1_CNT), .DROP_CNT(DROP_CNT)
`endif
   );

   assign FIFO_FULL  = force_full | (q_size >= DEPTH);
   assign FIFO_EMPTY = hold_empty | (q_size == 0);

   always @(posedge CLK) begin
      if (RST) begin
         fq.delete();
         FIFO_VALID <= 1'b0;
         FIFO_DOUT  <= '0;
         q_size     <= 0;
      end else begin
         if (FIFO_WR) fq.push_back(FIFO_DIN);
         if (load_en) fq.push_back(load_data);
         FIFO_VALID <= FIFO_RD;
         if (FIFO_RD && fq.size() > 0) FIFO_DOUT <= fq.pop_front();
         q_size <= fq.size();
      end
   end

   task automatic clear_inputs();
      REQ0_VALID = 0; REQ1_VALID = 0; REQ0_DATA = '0; REQ1_DATA = '0;
      OUT_READY = 0; force_full = 0; hold_empty = 0; load_en = 0; load_data = '0;
   endtask

   task automatic do_reset();
      RST = 1;
      clear_inputs();
      repeat (2) @(negedge CLK);
      RST = 0;
   endtask

   task automatic preload(input logic [15:0] w0, input logic [15:0] w1,
                          input logic [15:0] w2, input logic [15:0] w3, input int n);
      logic [15:0] w[4];
      w = '{w0, w1, w2, w3};
      hold_empty = 1;
      for (int i = 0; i < n; i++) begin
         load_en = 1; load_data = w[i];
         @(negedge CLK);
      end
      load_en = 0;
   endtask

   task automatic test_reset();
      RST = 1;
      clear_inputs();
      REQ0_VALID = 1; REQ1_VALID = 1; REQ0_DATA = 16'h1234; REQ1_DATA = 16'h4321;
      OUT_READY = 1;
      @(negedge CLK);
      #1;
      vectors++; if (FIFO_WR !== 1'b0) begin miscompares++; $display("FAIL reset_wr: got %b expected 0", FIFO_WR); end
      vectors++; if ({REQ0_READY, REQ1_READY} !== 2'b00) begin miscompares++; $display("FAIL reset_ready: got %b expected 00", {REQ0_READY, REQ1_READY}); end
      vectors++; if (FIFO_RD !== 1'b0) begin miscompares++; $display("FAIL reset_rd: got %b expected 0", FIFO_RD); end
      vectors++; if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", OUT_VALID); end
      vectors++; if (OUT_DATA !== 16'h0000) begin miscompares++; $display("FAIL reset_out_data: got %h expected 0000", OUT_DATA); end
      do_reset();
   endtask

   task automatic test_sole_requester();
      do_reset();
      REQ0_VALID = 1; REQ0_DATA = 16'h5a5a; OUT_READY = 1;
      for (int i = 0; i < 10; i++) begin
         #1;
         vectors++; if (FIFO_WR !== 1'b1) begin miscompares++; $display("FAIL sole_wr[%0d]: got %b expected 1", i, FIFO_WR); end
         vectors++; if ({REQ0_READY, REQ1_READY} !== 2'b10) begin miscompares++; $display("FAIL sole_ready[%0d]: got %b expected 10", i, {REQ0_READY, REQ1_READY}); end
         vectors++; if (FIFO_DIN !== 16'h5a5a) begin miscompares++; $display("FAIL sole_din[%0d]: got %h expected 5a5a", i, FIFO_DIN); end
         @(negedge CLK);
      end
   endtask

   task automatic test_round_robin();
      logic [15:0] e;
      do_reset();
      REQ0_VALID = 1; REQ0_DATA = 16'h1111;
      REQ1_VALID = 1; REQ1_DATA = 16'h2222;
      OUT_READY = 1;
      for (int i = 0; i < 12; i++) begin
         e = ((i / 4) % 2 == 0) ? 16'h1111 : 16'h2222;
         #1;
         vectors++; if (FIFO_WR !== 1'b1) begin miscompares++; $display("FAIL rr_wr[%0d]: got %b expected 1", i, FIFO_WR); end
         vectors++; if (FIFO_DIN !== e) begin miscompares++; $display("FAIL rr_din[%0d]: got %h expected %h", i, FIFO_DIN, e); end
         vectors++; if (REQ0_READY !== (e == 16'h1111)) begin miscompares++; $display("FAIL rr_ready0[%0d]: got %b expected %b", i, REQ0_READY, e == 16'h1111); end
         @(negedge CLK);
      end
   endtask

   task automatic test_full_stall();
      logic [15:0] exp_din [12];
      exp_din = '{16'h1111, 16'h1111, 16'h0000, 16'h0000, 16'h0000, 16'h1111,
                  16'h1111, 16'h2222, 16'h2222, 16'h2222, 16'h2222, 16'h1111};
      do_reset();
      REQ0_VALID = 1; REQ0_DATA = 16'h1111;
      REQ1_VALID = 1; REQ1_DATA = 16'h2222;
      OUT_READY = 1;
      for (int i = 0; i < 12; i++) begin
         force_full = (i >= 2 && i <= 4);
         #1;
         vectors++; if (FIFO_WR !== (exp_din[i] != 16'h0000)) begin miscompares++; $display("FAIL full_wr[%0d]: got %b expected %b", i, FIFO_WR, exp_din[i] != 16'h0000); end
         vectors++; if (FIFO_DIN !== exp_din[i]) begin miscompares++; $display("FAIL full_din[%0d]: got %h expected %h", i, FIFO_DIN, exp_din[i]); end
         vectors++; if ({REQ0_READY, REQ1_READY} !== {exp_din[i] == 16'h1111, exp_din[i] == 16'h2222}) begin
            miscompares++; $display("FAIL full_ready[%0d]: got %b expected %b", i, {REQ0_READY, REQ1_READY}, {exp_din[i] == 16'h1111, exp_din[i] == 16'h2222});
         end
         @(negedge CLK);
      end
      force_full = 0;
   endtask

   task automatic test_read_pacing();
      logic       e_rd, e_ov;
      do_reset();
      preload(16'h0001, 16'h0002, 16'h0003, 16'h0004, 4);
      hold_empty = 0; OUT_READY = 1;
      for (int k = 0; k < 10; k++) begin
         e_rd = (k % 2 == 0) && (k <= 6);
         e_ov = (k % 2 == 0) && (k >= 2) && (k <= 8);
         #1;
         vectors++; if (FIFO_RD !== e_rd) begin miscompares++; $display("FAIL pace_rd[%0d]: got %b expected %b", k, FIFO_RD, e_rd); end
         vectors++; if (OUT_VALID !== e_ov) begin miscompares++; $display("FAIL pace_ov[%0d]: got %b expected %b", k, OUT_VALID, e_ov); end
         if (e_ov) begin
            vectors++; if (OUT_DATA !== 16'(k / 2)) begin miscompares++; $display("FAIL pace_data[%0d]: got %h expected %h", k, OUT_DATA, 16'(k / 2)); end
         end
         @(negedge CLK);
      end
   endtask

   task automatic test_out_stall();
      do_reset();
      preload(16'h00a1, 16'h00a2, 16'h00a3, 16'h0000, 3);
      hold_empty = 0; OUT_READY = 0;
      for (int k = 0; k < 8; k++) begin
         #1;
         vectors++; if (FIFO_RD !== (k == 0)) begin miscompares++; $display("FAIL stall_rd[%0d]: got %b expected %b", k, FIFO_RD, k == 0); end
         if (k >= 2) begin
            vectors++; if ({OUT_VALID, OUT_DATA} !== {1'b1, 16'h00a1}) begin miscompares++; $display("FAIL stall_out[%0d]: got %b/%h expected 1/00a1", k, OUT_VALID, OUT_DATA); end
         end
         @(negedge CLK);
      end
      OUT_READY = 1;
      #1;
      vectors++; if (FIFO_RD !== 1'b1) begin miscompares++; $display("FAIL stall_release_rd: got %b expected 1", FIFO_RD); end
      @(negedge CLK);
   endtask

   task automatic test_reset_mid_read();
      do_reset();
      preload(16'h0bb1, 16'h0bb2, 16'h0000, 16'h0000, 2);
      hold_empty = 0; OUT_READY = 1;
      #1;
      vectors++; if (FIFO_RD !== 1'b1) begin miscompares++; $display("FAIL mid_rd: got %b expected 1", FIFO_RD); end
      @(negedge CLK);
      RST = 1;
      @(negedge CLK);
      #1;
      vectors++; if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL mid_ov_rst: got %b expected 0", OUT_VALID); end
      vectors++; if (FIFO_RD !== 1'b0) begin miscompares++; $display("FAIL mid_rd_rst: got %b expected 0", FIFO_RD); end
      RST = 0;
      @(negedge CLK);
      #1;
      vectors++; if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL mid_ov_after: got %b expected 0", OUT_VALID); end
      @(negedge CLK);
      preload(16'h0cc1, 16'h0000, 16'h0000, 16'h0000, 1);
      hold_empty = 0;
      #1;
      vectors++; if (FIFO_RD !== 1'b1) begin miscompares++; $display("FAIL mid_inflight_clear: got %b expected 1", FIFO_RD); end
      @(negedge CLK);
      @(negedge CLK);
      #1;
      vectors++; if ({OUT_VALID, OUT_DATA} !== {1'b1, 16'h0cc1}) begin miscompares++; $display("FAIL mid_next_word: got %b/%h expected 1/0cc1", OUT_VALID, OUT_DATA); end
`ifdef FIFO_RR_CTRL_STATS_EN
      vectors++; if (DROP_CNT !== 16'd0) begin miscompares++; $display("FAIL mid_drop_cnt: got %0d expected 0", DROP_CNT); end
`endif
      @(negedge CLK);
   endtask

   task automatic test_random_traffic();
      logic [15:0] sb[$];
      logic [15:0] e;
      int          drained;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         REQ0_VALID = ($urandom_range(0, 3) != 0);
         REQ1_VALID = ($urandom_range(0, 1) != 0);
         REQ0_DATA  = 16'($urandom);
         REQ1_DATA  = 16'($urandom);
         OUT_READY  = ($urandom_range(0, 2) != 0);
         force_full = ($urandom_range(0, 7) == 0);
         #1;
         if (REQ0_READY) sb.push_back(REQ0_DATA);
         if (REQ1_READY) sb.push_back(REQ1_DATA);
         if (OUT_VALID && OUT_READY) begin
            e = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
            vectors++; if (OUT_DATA !== e) begin miscompares++; $display("FAIL rand_data[%0d]: got %h expected %h", c, OUT_DATA, e); end
         end
         @(negedge CLK);
      end
      REQ0_VALID = 0; REQ1_VALID = 0; force_full = 0; OUT_READY = 1;
      drained = 0;
      for (int c = 0; c < 200 && drained == 0; c++) begin
         #1;
         if (OUT_VALID && OUT_READY) begin
            e = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
            vectors++; if (OUT_DATA !== e) begin miscompares++; $display("FAIL drain_data[%0d]: got %h expected %h", c, OUT_DATA, e); end
         end
         if (sb.size() == 0 && !OUT_VALID && !FIFO_VALID && q_size == 0) drained = 1;
         @(negedge CLK);
      end
      vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL rand_lost_words: got %0d expected 0", sb.size()); end
`ifdef FIFO_RR_CTRL_STATS_EN
      vectors++; if (DROP_CNT !== 16'd0) begin miscompares++; $display("FAIL rand_drop_cnt: got %0d expected 0", DROP_CNT); end
`endif
   endtask

   initial begin
      test_reset();
      test_sole_requester();
      test_round_robin();
      test_full_stall();
      test_read_pacing();
      test_out_stall();
      test_reset_mid_read();
      test_random_traffic();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
